// File: rtl/sweeper_pkg.sv
// -----------------------------------------------------------------------------
// sweeper_pkg
// Shared types and width helpers for the truth-table sweeper.
//   state_t       : sweep FSM states (IDLE, SWEEP, DONE)
//   vec_width()   : stimulus vector width for an N_IN-input DUT
//   count_width() : mismatch counter width; holds the full 2^N_IN count
//   hold_width()  : hold counter width for a given HOLD
// -----------------------------------------------------------------------------
package sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int vec_width(input int n_in);
        return n_in;
    endfunction

    // One extra bit so a DUT that fails on every vector still fits.
    function automatic int count_width(input int n_in);
        return n_in + 1;
    endfunction

    // Sized on HOLD+1 so HOLD=1 still gets a one-bit counter.
    function automatic int hold_width(input int hold);
        return $clog2(hold + 1);
    endfunction

endpackage : sweeper_pkg

// File: rtl/sweep_counter.sv
// -----------------------------------------------------------------------------
// sweep_counter
// Stimulus vector register plus per-vector hold counter.
//   clock     : rising-edge clock
//   reset     : asynchronous, active-high reset
//   clear     : synchronous clear of vector and hold counter (sweep start)
//   run       : hold counter advances while high
//   step      : on the final hold cycle, advance to the next vector
//   vec       : current stimulus vector
//   last_hold : strobe, current cycle is the final hold cycle of vec
//   last_vec  : vec is the all-ones (final) vector
// -----------------------------------------------------------------------------
module sweep_counter
    import sweeper_pkg::*;
#(
    parameter int N_IN = 3,
    parameter int HOLD = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    input  logic            run,
    input  logic            step,
    output logic [N_IN-1:0] vec,
    output logic            last_hold,
    output logic            last_vec
);

    localparam int VW = vec_width(N_IN);
    localparam int HW = hold_width(HOLD);

    localparam logic [VW-1:0] VEC_ONE   = VW'(1);
    localparam logic [VW-1:0] VEC_LAST  = {VW{1'b1}};
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    logic [HW-1:0] hold_cnt;

    assign last_hold = (hold_cnt == HOLD_LAST);
    assign last_vec  = (vec == VEC_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vec      <= '0;
            hold_cnt <= '0;
        end else if (clear) begin
            vec      <= '0;
            hold_cnt <= '0;
        end else if (run) begin
            if (last_hold) begin
                hold_cnt <= '0;
                // The FSM withholds step on the final/stopping vector so
                // the vector is left on the DUT inputs after the sweep.
                if (step) begin
                    vec <= vec + VEC_ONE;
                end
            end else begin
                hold_cnt <= hold_cnt + HOLD_ONE;
            end
        end
    end

endmodule : sweep_counter

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Exhaustive stimulus engine for a small single-output combinational DUT.
// Drives every input vector in ascending order for HOLD cycles each, compares
// the DUT response on the last hold cycle against EXPECTED, and reports the
// mismatch count and the lowest failing vector.
//
// Parameters:
//   N_IN     : DUT input count (1..8)
//   HOLD     : cycles each vector is driven (>=1)
//   EXPECTED : truth table, bit k = expected output for vector k
// Ports:
//   clock            : rising-edge clock
//   reset            : asynchronous, active-high reset
//   start            : begin a sweep (ignored while a sweep runs)
//   dut_in           : stimulus vector to the DUT
//   dut_out          : DUT response
//   busy             : sweep in progress
//   done             : sweep complete, results valid
//   pass             : done with zero mismatches
//   err_count        : number of mismatching vectors
//   first_fail       : lowest failing vector
//   first_fail_valid : first_fail holds a real value
//
// Build option:
//   SWEEPER_STOP_ON_FAIL_EN : end the sweep on the first mismatch, leaving the
//                             failing vector on dut_in.
// -----------------------------------------------------------------------------
module truth_table_sweeper
    import sweeper_pkg::*;
#(
    parameter int                  N_IN     = 3,
    parameter int                  HOLD     = 1,
    parameter logic [2**N_IN-1:0]  EXPECTED = 8'b1110_1000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail,
    output logic            first_fail_valid
);

    localparam int CW = count_width(N_IN);
    localparam logic [CW-1:0] ERR_ONE = CW'(1);

`ifdef SWEEPER_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    state_t          state;
    state_t          next_state;
    logic            clear;
    logic            run;
    logic            step;
    logic            mismatch;
    logic [N_IN-1:0] vec;
    logic            last_hold;
    logic            last_vec;

    sweep_counter #(
        .N_IN (N_IN),
        .HOLD (HOLD)
    ) u_counter (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .run       (run),
        .step      (step),
        .vec       (vec),
        .last_hold (last_hold),
        .last_vec  (last_vec)
    );

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and control decode
    // ---------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        clear      = 1'b0;
        run        = 1'b0;
        step       = 1'b0;
        mismatch   = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    next_state = SWEEP;
                end
            end

            SWEEP: begin
                run = 1'b1;
                if (last_hold) begin
                    mismatch = (dut_out != EXPECTED[vec]);
                    if (last_vec || (STOP_ON_FAIL && mismatch)) begin
                        next_state = DONE;
                    end else begin
                        step = 1'b1;
                    end
                end
            end

            DONE: begin
                if (start) begin
                    clear      = 1'b1;
                    next_state = SWEEP;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Result registers. err_count cannot wrap: at most 2^N_IN mismatches
    // are counted and the register is N_IN+1 bits wide.
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_count        <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else if (clear) begin
            err_count        <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else if (mismatch) begin
            err_count <= err_count + ERR_ONE;
            // Vectors ascend, so the first recorded failure is the lowest.
            if (!first_fail_valid) begin
                first_fail       <= vec;
                first_fail_valid <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign dut_in = (state == IDLE) ? '0 : vec;
    assign busy   = (state == SWEEP);
    assign done   = (state == DONE);
    assign pass   = (state == DONE) && (err_count == '0);

endmodule : truth_table_sweeper

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
// Two sweepers (HOLD=1 and HOLD=3) each beside a 3-input majority gate with a
// per-vector fault mask. Expected vector sequences are queued when a sweep is
// started and popped as the sweeper drives them; final results come from a
// table of sweep cases.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

    localparam int BOUND = 100;

    logic       clock;
    logic       reset;
    logic       start1;
    logic       start3;
    logic [7:0] fault;

    logic [2:0] dut_in1,   dut_in3;
    logic       dut_out1,  dut_out3;
    logic       busy1,     busy3;
    logic       done1,     done3;
    logic       pass1,     pass3;
    logic [3:0] err1,      err3;
    logic [2:0] ff1,       ff3;
    logic       ffv1,      ffv3;

    // Observed signals of the instance under test (sel=0: HOLD=1, sel=1: HOLD=3)
    logic       sel;
    logic [2:0] o_dut_in;
    logic       o_busy, o_done, o_pass, o_ffv;
    logic [3:0] o_err;
    logic [2:0] o_ff;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    typedef struct {
        bit         s;        // instance select
        logic [7:0] fault;    // DUT fault mask, bit k inverts vector k
        int         glitch;   // vector at which start is pulsed, -1 = none
        int         exp_err;
        int         exp_ff;
        int         exp_ffv;
        int         exp_pass;
        int         exp_lat;  // cycles from start edge to done
        int         exp_last; // dut_in left after the sweep
    } case_t;

    case_t cases[7];

    function automatic logic majority(input logic [2:0] v);
        return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    endfunction

    assign dut_out1 = majority(dut_in1) ^ fault[dut_in1];
    assign dut_out3 = majority(dut_in3) ^ fault[dut_in3];

    truth_table_sweeper #(.N_IN(3), .HOLD(1), .EXPECTED(8'b1110_1000)) u_dut1 (
        .clock(clock), .reset(reset), .start(start1),
        .dut_in(dut_in1), .dut_out(dut_out1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail(ff1), .first_fail_valid(ffv1)
    );

    truth_table_sweeper #(.N_IN(3), .HOLD(3), .EXPECTED(8'b1110_1000)) u_dut3 (
        .clock(clock), .reset(reset), .start(start3),
        .dut_in(dut_in3), .dut_out(dut_out3),
        .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .first_fail(ff3), .first_fail_valid(ffv3)
    );

    always_comb begin
        o_dut_in = sel ? dut_in3 : dut_in1;
        o_busy   = sel ? busy3   : busy1;
        o_done   = sel ? done3   : done1;
        o_pass   = sel ? pass3   : pass1;
        o_err    = sel ? err3    : err1;
        o_ff     = sel ? ff3     : ff1;
        o_ffv    = sel ? ffv3    : ffv1;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic drive_start(input bit s, input logic v);
        if (s) start3 = v;
        else   start1 = v;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dut_in"}, o_dut_in, 0);
        check({tag, "_busy"},   o_busy,   0);
        check({tag, "_done"},   o_done,   0);
        check({tag, "_pass"},   o_pass,   0);
        check({tag, "_err"},    o_err,    0);
        check({tag, "_ff"},     o_ff,     0);
        check({tag, "_ffv"},    o_ffv,    0);
    endtask

    task automatic run_case(input int idx, input case_t c);
        int  hold;
        int  cyc;
        int  exp_v;
        bit  done_seen;
        bit  glitched;
        bit  release_pending;

        hold            = c.s ? 3 : 1;
        sel             = c.s;
        fault           = c.fault;
        done_seen       = 1'b0;
        glitched        = 1'b0;
        release_pending = 1'b0;
        cyc             = 0;

        // Scoreboard: every cycle of the sweep expects one queued vector.
        exp_q.delete();
        for (int v = 0; v <= c.exp_last; v++) begin
            for (int h = 0; h < hold; h++) begin
                exp_q.push_back(v);
            end
        end

        @(negedge clock);
        drive_start(c.s, 1'b1);
        @(posedge clock);
        #1;
        drive_start(c.s, 1'b0);
        check($sformatf("c%0d_busy_after_start", idx), o_busy, 1);
        check($sformatf("c%0d_done_after_start", idx), o_done, 0);
        check($sformatf("c%0d_err_cleared", idx), o_err, 0);
        check($sformatf("c%0d_ffv_cleared", idx), o_ffv, 0);

        while (!done_seen && cyc <= BOUND) begin
            if (release_pending) begin
                drive_start(c.s, 1'b0);
                release_pending = 1'b0;
            end
            if (o_done) begin
                done_seen = 1'b1;
            end else begin
                if (exp_q.size() == 0) begin
                    check($sformatf("c%0d_queue_underflow", idx), 1, 0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check($sformatf("c%0d_dut_in_cyc%0d", idx, cyc), o_dut_in, exp_v);
                end
                check($sformatf("c%0d_busy_cyc%0d", idx, cyc), o_busy, 1);
                if (c.glitch >= 0 && !glitched && int'(o_dut_in) == c.glitch) begin
                    drive_start(c.s, 1'b1);
                    glitched        = 1'b1;
                    release_pending = 1'b1;
                end
                @(posedge clock);
                #1;
                cyc++;
            end
        end
        drive_start(c.s, 1'b0);

        if (!done_seen) begin
            check($sformatf("c%0d_done_timeout", idx), 0, 1);
        end else begin
            check($sformatf("c%0d_latency", idx), cyc, c.exp_lat);
            check($sformatf("c%0d_queue_left", idx), exp_q.size(), 0);
            check($sformatf("c%0d_last_vec", idx), o_dut_in, c.exp_last);
            check($sformatf("c%0d_err_count", idx), o_err, c.exp_err);
            check($sformatf("c%0d_first_fail", idx), o_ff, c.exp_ff);
            check($sformatf("c%0d_ffv", idx), o_ffv, c.exp_ffv);
            check($sformatf("c%0d_pass", idx), o_pass, c.exp_pass);
            check($sformatf("c%0d_busy_done", idx), o_busy, 0);
            @(posedge clock);
            #1;
            check($sformatf("c%0d_done_holds", idx), o_done, 1);
            check($sformatf("c%0d_err_holds", idx), o_err, c.exp_err);
        end
    endtask

    initial begin
        // Default build: full sweeps, every mismatch counted.
        //           s  fault   glitch err ff ffv pass lat last
        cases[0] = '{0, 8'h00, -1,    0,  0, 0,  1,   8,  7};
        cases[1] = '{0, 8'h60, -1,    2,  5, 1,  0,   8,  7};
        cases[2] = '{0, 8'h00,  2,    0,  0, 0,  1,   8,  7};
        cases[3] = '{1, 8'h00, -1,    0,  0, 0,  1,  24,  7};
        cases[4] = '{1, 8'h81, -1,    2,  0, 1,  0,  24,  7};
        cases[5] = '{0, 8'h04, -1,    1,  2, 1,  0,   8,  7};
        cases[6] = '{0, 8'hFF, -1,    8,  0, 1,  0,   8,  7};
`ifdef SWEEPER_STOP_ON_FAIL_EN
        // Stop on first mismatch: sweep ends on the failing compare edge.
        cases[1] = '{0, 8'h60, -1,    1,  5, 1,  0,   6,  5};
        cases[4] = '{1, 8'h81, -1,    1,  0, 1,  0,   3,  0};
        cases[5] = '{0, 8'h04, -1,    1,  2, 1,  0,   3,  2};
        cases[6] = '{0, 8'hFF, -1,    1,  0, 1,  0,   1,  0};
`endif

        reset  = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        fault  = 8'h00;
        sel    = 1'b0;

        #12;
        check_all_zero("reset1");
        sel = 1'b1;
        #1;
        check_all_zero("reset3");
        sel = 1'b0;

        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("idle_no_start_busy", o_busy, 0);

        for (int i = 0; i < 7; i++) begin
            run_case(i, cases[i]);
        end

        // Reset asserted mid-sweep while vector 4 is on dut_in.
        sel   = 1'b0;
        fault = 8'h00;
        @(negedge clock);
        start1 = 1'b1;
        @(posedge clock);
        #1;
        start1 = 1'b0;
        for (int i = 0; i < 20 && o_dut_in != 3'd4; i++) begin
            @(posedge clock);
            #1;
        end
        check("reached_vec4", o_dut_in, 4);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("post_reset_busy", o_busy, 0);
        check("post_reset_done", o_done, 0);
        check("post_reset_dut_in", o_dut_in, 0);
        run_case(7, cases[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_truth_table_sweeper

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Self-checking exhaustive stimulus engine for small combinational blocks under lab test. On `start`, it drives every input combination of an N-input DUT in ascending binary order and holds each vector for a programmable number of cycles. It samples the DUT's single output and compares it against a parameterised expected truth table, then reports pass/fail, the mismatch count and the first failing vector. It sits beside the DUT in a bench or FPGA wrapper and replaces hand-written vector lists.

## Interface
- `N_IN`, 3, DUT input count; legal 1..8
- `HOLD`, 1, cycles each vector is driven; legal ≥1
- `EXPECTED`, 8'b1110_1000, 2^N_IN-bit truth table; bit k = expected output for input vector k
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  begin sweep; sampled on `clock`
- `dut_in`  out  N_IN  current stimulus vector; bit N_IN-1 = MSB (a_in in 3-input case)
- `dut_out`  in  1  DUT response
- `busy`  out  1  sweep in progress
- `done`  out  1  sweep complete, results valid
- `pass`  out  1  done and zero mismatches
- `err_count`  out  N_IN+1  number of mismatching vectors
- `first_fail`  out  N_IN  lowest failing vector
- `first_fail_valid`  out  1  `first_fail` holds a real value

## Operation
- FSM states: IDLE, SWEEP, DONE.
- IDLE: `dut_in`=0, `busy`=0, `done`=0. When `start`=1 → SWEEP. Entering SWEEP clears `vec`, the hold counter, `err_count`, `first_fail` and `first_fail_valid`.
- SWEEP: `dut_in`=`vec`, `busy`=1. The hold counter counts 0..HOLD-1.
  - On the edge ending the final hold cycle, compare `dut_out` with `EXPECTED[vec]`.
  - On a mismatch, increment `err_count`. If `first_fail_valid`=0, load `first_fail`=`vec` and set `first_fail_valid`.
  - After the compare, if `vec`=2^N_IN-1 → DONE. Otherwise increment `vec` and reset the hold counter.
- DONE: `done`=1, `busy`=0, `pass`=(`err_count`==0). `dut_in` holds the last vector. Results hold until `start`, which restarts SWEEP with cleared results.
- `start` during SWEEP is ignored.
- `err_count` never wraps. Its width covers the maximum of 2^N_IN.
- `vec` and the hold counter are sized so they never wrap within a sweep.

## Timing
- Reset (async, immediate): state=IDLE. All outputs are 0, including `dut_in`, `err_count`, `first_fail`, `pass`, `done`, `busy` and `first_fail_valid`.
- Reset asserted mid-sweep aborts the sweep with no partial results retained. After reset deasserts, the block needs a fresh `start`.
- `start` high at edge t: `busy`=1 and `dut_in`=0 from t+1.
- Each vector is driven for exactly HOLD cycles. `dut_out` must settle within the cycle, since the DUT is treated as combinational.
- The last compare happens at edge t+HOLD·2^N_IN, and `done`=1 from that edge. Total latency from `start` to `done` is HOLD·2^N_IN cycles.
- `err_count` and `first_fail` update on the compare edge. They are visible the cycle after.

## Configuration
- `SWEEPER_STOP_ON_FAIL_EN` defined: the first mismatch moves SWEEP → DONE on the same compare edge, so `err_count`=1 at most. `dut_in` holds the failing vector.
- Macro undefined: the full sweep always completes and every mismatch is counted.

## Structure
- Package `sweeper_pkg` holds:
  - the state enum (IDLE, SWEEP, DONE)
  - width helper constants: vector width = N_IN, count width = N_IN+1, hold counter width = $clog2(HOLD+1)
- Sub-module `sweep_counter`: vector plus hold counter, with a `last_hold` strobe and a `last_vec` flag. The top holds the FSM, compare logic and result registers.

## Test plan
- N_IN=3, HOLD=1, EXPECTED=8'b1110_1000, DUT = correct majority: `dut_in` steps 0..7 one per cycle. `done` rises 8 cycles after `start`, with `pass`=1, `err_count`=0 and `first_fail_valid`=0.
- Same, with DUT output inverted at vectors 5 and 6: `err_count`=2, `first_fail`=5, `pass`=0.
- HOLD=3, correct DUT: each vector held 3 cycles, `done` 24 cycles after `start`, `pass`=1.
- Assert `reset` while `dut_in`=4: all outputs 0 immediately, IDLE. A new `start` gives a complete sweep from vector 0.
- `start` pulsed at vector 2 is ignored. `start` in DONE restarts from vector 0 with cleared `err_count`.
- With `SWEEPER_STOP_ON_FAIL_EN` and a fault at vector 2: `done` 3 cycles after `start`, `err_count`=1, `first_fail`=2, `dut_in`=2.
